pwm_duty_sched: RTL and testbench
=================================

// Module: pwm_duty_sched
// PURPOSE
//  Duty-cycle scheduler and over-current supervisor for the PWM11 half-bridge modulator.
//  - Sequences the 11-bit duty into PWM11: soft-start ramp, period-aligned updates, clamp.
//  - Turns unblanked over-current samples into a latched fault that forces duty to zero.
//  - Sits between the motor control loop (duty_req) and PWM11 (duty, PWM_synch, ovr_I_blank).
// PARAMETERS
//  RAMP_STEP    11'd16   max duty change per PWM period (LSBs)
//  MAX_DUTY     11'h7BF  duty ceiling (2047-64); keeps duty+NONOVERLAP from wrapping
//  TRIP_PERIODS 4        consecutive periods with an unblanked OVR_I needed to trip
//  RETRY_PERIODS 1024    FAULT hold-off before auto-retry (AUTO_RETRY_EN only)
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  enable       in   1   drive enable from the control loop
//  duty_req     in   11  requested duty (unsigned)
//  PWM_synch    in   1   PWM11 period start (cnt==0), one clk wide
//  ovr_I_blank  in   1   PWM11 blanking window; OVR_I ignored while high
//  OVR_I        in   1   over-current comparator, already synchronised
//  clr_fault    in   1   clears FAULT (honoured only when enable=0)
//  duty         out  11  registered duty to PWM11
//  running      out  1   high in RAMP or RUN
//  fault        out  1   high in FAULT
// BEHAVIOUR
//  Reset: state=IDLE, duty=0, running=0, fault=0, oc_seen=0, trip_cnt=0, retry_cnt=0.
//  Reset mid-operation aborts any state immediately; duty goes to 0 asynchronously.
//  duty_tgt = min(duty_req, MAX_DUTY). duty changes only on a clk edge where PWM_synch=1.
//  PWM11 therefore sees a new duty from cnt==1 onward; duty is constant within a period.
//  States:
//   IDLE : duty=0. When enable=1 and PWM_synch=1 -> RAMP. That update is the first ramp step.
//   RAMP : each PWM_synch, duty moves toward duty_tgt by at most RAMP_STEP, up or down.
//          A step that would overshoot lands exactly on duty_tgt.
//          Go to RUN in the same update where duty becomes equal to duty_tgt.
//   RUN  : each PWM_synch, duty tracks duty_tgt using the same RAMP_STEP slew.
//          The FSM stays in RUN.
//   FAULT: duty=0 on the entry edge (not period-aligned); fault=1, running=0.
//          Exit to IDLE when clr_fault=1 && enable=0.
//  enable=0 in RAMP/RUN: duty ramps down by RAMP_STEP per period.
//   Enter IDLE at the update where duty reaches 0.
//   enable re-asserted before then: ramp back up toward duty_tgt (RAMP).
//  Over-current detection (RAMP/RUN only):
//   - oc_seen sets on any clk with OVR_I=1 && ovr_I_blank=0.
//   - On PWM_synch: trip_cnt = oc_seen ? trip_cnt+1 : 0, and oc_seen clears.
//   - OVR_I on the PWM_synch cycle itself counts toward the new period.
//   - When trip_cnt reaches TRIP_PERIODS -> FAULT on that edge.
//   - trip_cnt saturates; it clears on entry to IDLE.
//  Simultaneous events, highest priority first:
//   1. rst_n
//   2. trip to FAULT
//   3. enable drop
//   4. ramp/track update
//  clr_fault with enable=1 is ignored. OVR_I in IDLE/FAULT is ignored.
//  All arithmetic is unsigned 11-bit; ramp add/subtract is computed 12-bit and clamped to [0, duty_tgt].
// CONFIGURATION
//  AUTO_RETRY_EN defined:
//   - FAULT counts PWM_synch pulses in retry_cnt.
//   - After RETRY_PERIODS with enable=1 -> IDLE, which re-ramps from 0.
//   - clr_fault still works.
//  AUTO_RETRY_EN undefined: retry_cnt is absent; FAULT exits only via clr_fault && enable=0.
// TESTING
//  1. enable=1, duty_req=11'd100, RAMP_STEP=16:
//     duty goes 16,32,...,96,100 on successive PWM_synch; RUN on the 100 update.
//  2. In RUN at 100, duty_req->11'h7FF:
//     duty slews +16 per period and saturates at 11'h7BF; never exceeds MAX_DUTY.
//  3. OVR_I pulses only inside ovr_I_blank for 10 periods:
//     no trip. Pulse outside blanking for 4 consecutive periods: fault=1, duty=0 on that edge.
//  4. OVR_I unblanked in 3 periods, then one clean period, then 3 more: no trip (trip_cnt resets).
//  5. FAULT, clr_fault=1 with enable=1: stays FAULT. enable=0 + clr_fault=1: IDLE next clk.
//  6. rst_n low mid-RAMP at duty=48: duty=0, state=IDLE immediately.
//     With AUTO_RETRY_EN: FAULT returns to IDLE after 1024 PWM_synch pulses.

Source files
------------

// File: rtl/pwm_duty_sched.sv
// Duty-cycle scheduler and over-current supervisor for the PWM11 half-bridge modulator.
// Optional build macro AUTO_RETRY_EN: FAULT self-clears after RETRY_PERIODS periods with enable held.
module pwm_duty_sched #(
    parameter logic [10:0] RAMP_STEP     = 11'd16,
    parameter logic [10:0] MAX_DUTY      = 11'h7BF,
    parameter logic [2:0]  TRIP_PERIODS  = 3'd4,
    parameter logic [10:0] RETRY_PERIODS = 11'd1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [10:0] duty_req,
    input  logic        PWM_synch,
    input  logic        ovr_I_blank,
    input  logic        OVR_I,
    input  logic        clr_fault,
    output logic [10:0] duty,
    output logic        running,
    output logic        fault
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t      state_r;
    logic        oc_seen_r;
    logic [2:0]  trip_cnt_r;
    logic [10:0] duty_tgt_s;
    logic [10:0] slew_tgt_s;
    logic [10:0] duty_nxt_s;
    logic [2:0]  trip_nxt_s;
    logic        oc_hit_s;
`ifdef AUTO_RETRY_EN
    logic [10:0] retry_cnt_r;
    logic [10:0] retry_nxt_s;
`endif

    // One slew step toward tgt; overshoot in either direction lands exactly on tgt.
    function automatic logic [10:0] slew_toward(input logic [10:0] cur,
                                                input logic [10:0] tgt,
                                                input logic [10:0] step);
        logic [11:0] up_v;
        logic [11:0] dn_v;
        logic [10:0] res_v;
        up_v = {1'b0, cur} + {1'b0, step};
        dn_v = {1'b0, cur} - {1'b0, step};
        if (cur < tgt) begin
            if (up_v > {1'b0, tgt}) begin
                res_v = tgt;
            end else begin
                res_v = up_v[10:0];
            end
        end else if (cur > tgt) begin
            if (dn_v[11] || (dn_v < {1'b0, tgt})) begin
                res_v = tgt;
            end else begin
                res_v = dn_v[10:0];
            end
        end else begin
            res_v = cur;
        end
        return res_v;
    endfunction

    // Target clamp, next slew value and next trip count for the coming period boundary.
    always_comb begin
        duty_tgt_s = (duty_req > MAX_DUTY) ? MAX_DUTY : duty_req;
        slew_tgt_s = enable ? duty_tgt_s : 11'd0;
        duty_nxt_s = slew_toward(duty, slew_tgt_s, RAMP_STEP);
        oc_hit_s   = OVR_I & ~ovr_I_blank;
        if (!oc_seen_r) begin
            trip_nxt_s = 3'd0;
        end else if (trip_cnt_r >= TRIP_PERIODS) begin
            trip_nxt_s = trip_cnt_r;
        end else begin
            trip_nxt_s = trip_cnt_r + 3'd1;
        end
`ifdef AUTO_RETRY_EN
        if (retry_cnt_r >= RETRY_PERIODS) begin
            retry_nxt_s = retry_cnt_r;
        end else begin
            retry_nxt_s = retry_cnt_r + 11'd1;
        end
`endif
    end

    // Scheduler FSM with registered duty/running/fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            duty       <= 11'd0;
            running    <= 1'b0;
            fault      <= 1'b0;
            oc_seen_r  <= 1'b0;
            trip_cnt_r <= 3'd0;
`ifdef AUTO_RETRY_EN
            retry_cnt_r <= 11'd0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    oc_seen_r  <= 1'b0;
                    trip_cnt_r <= 3'd0;
                    fault      <= 1'b0;
                    if (enable && PWM_synch) begin
                        state_r <= ST_RAMP;
                        duty    <= duty_nxt_s;
                        running <= 1'b1;
                    end else begin
                        duty    <= 11'd0;
                        running <= 1'b0;
                    end
                end
                ST_RAMP, ST_RUN: begin
                    if (PWM_synch) begin
                        // The synch cycle's own sample belongs to the period that starts here.
                        oc_seen_r  <= oc_hit_s;
                        trip_cnt_r <= trip_nxt_s;
                        if (trip_nxt_s >= TRIP_PERIODS) begin
                            state_r <= ST_FAULT;
                            duty    <= 11'd0;
                            running <= 1'b0;
                            fault   <= 1'b1;
`ifdef AUTO_RETRY_EN
                            retry_cnt_r <= 11'd0;
`endif
                        end else if (!enable) begin
                            duty <= duty_nxt_s;
                            if (duty_nxt_s == 11'd0) begin
                                state_r    <= ST_IDLE;
                                running    <= 1'b0;
                                oc_seen_r  <= 1'b0;
                                trip_cnt_r <= 3'd0;
                            end else begin
                                state_r <= ST_RAMP;
                            end
                        end else begin
                            duty <= duty_nxt_s;
                            if ((state_r == ST_RUN) || (duty_nxt_s == duty_tgt_s)) begin
                                state_r <= ST_RUN;
                            end else begin
                                state_r <= ST_RAMP;
                            end
                        end
                    end else begin
                        oc_seen_r <= oc_seen_r | oc_hit_s;
                    end
                end
                ST_FAULT: begin
                    duty    <= 11'd0;
                    running <= 1'b0;
                    if (clr_fault && !enable) begin
                        state_r    <= ST_IDLE;
                        fault      <= 1'b0;
                        trip_cnt_r <= 3'd0;
                        oc_seen_r  <= 1'b0;
`ifdef AUTO_RETRY_EN
                    end else if (PWM_synch) begin
                        retry_cnt_r <= retry_nxt_s;
                        if (enable && (retry_nxt_s >= RETRY_PERIODS)) begin
                            state_r    <= ST_IDLE;
                            fault      <= 1'b0;
                            trip_cnt_r <= 3'd0;
                            oc_seen_r  <= 1'b0;
                        end else begin
                            fault <= 1'b1;
                        end
`endif
                    end else begin
                        fault <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    duty    <= 11'd0;
                    running <= 1'b0;
                    fault   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_duty_sched.sv
// Scoreboard bench for pwm_duty_sched: stimulus queues expected outputs, monitors pop and compare.
module tb_pwm_duty_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [10:0] duty_req;
    logic        PWM_synch;
    logic        ovr_I_blank;
    logic        OVR_I;
    logic        clr_fault;
    logic [10:0] duty;
    logic        running;
    logic        fault;

    typedef struct {
        logic [10:0] duty;
        logic        running;
        logic        fault;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    logic chk = 1'b0;
    logic ck_q;
    event async_ev;

    always #5 clk = ~clk;

    pwm_duty_sched dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .duty_req(duty_req),
        .PWM_synch(PWM_synch), .ovr_I_blank(ovr_I_blank), .OVR_I(OVR_I),
        .clr_fault(clr_fault), .duty(duty), .running(running), .fault(fault)
    );

    task automatic compare_one();
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_underflow: output sampled with no expectation queued");
        end else begin
            e = exp_q.pop_front();
            if ({duty, running, fault} !== {e.duty, e.running, e.fault}) begin
                errors++;
                $display("FAIL %s: got duty=%0d running=%b fault=%b, expected duty=%0d running=%b fault=%b",
                         e.tag, duty, running, fault, e.duty, e.running, e.fault);
            end
        end
    endtask

    // Clocked monitor: compares outputs just after every edge the stimulus marked.
    initial begin
        forever begin
            @(posedge clk);
            ck_q = chk;
            #1;
            if (ck_q) compare_one();
        end
    end

    // Asynchronous monitor: used for checks that must hold before any clock edge.
    initial begin
        forever begin
            @(async_ev);
            #1;
            compare_one();
        end
    end

    task automatic push_exp(input logic [10:0] ed, input logic er, input logic ef, input string tag);
        exp_t e;
        e.duty = ed; e.running = er; e.fault = ef; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic s, input logic blank, input logic ovr, input logic do_chk,
                       input logic [10:0] ed, input logic er, input logic ef, input string tag);
        @(negedge clk);
        PWM_synch   = s;
        ovr_I_blank = blank;
        OVR_I       = ovr;
        chk         = do_chk;
        if (do_chk) push_exp(ed, er, ef, tag);
        @(posedge clk);
        #2;
    endtask

    // Four-clock PWM period; mode 1 = blanked OVR_I pulse, mode 2 = unblanked pulse.
    task automatic period(input int mode, input logic do_chk, input logic [10:0] ed,
                          input logic er, input logic ef, input string tag);
        cyc(1'b1, 1'b0, 1'b0, do_chk, ed, er, ef, tag);
        cyc(1'b0, 1'b1, (mode == 1), 1'b0, 11'd0, 1'b0, 1'b0, "");
        cyc(1'b0, 1'b0, (mode == 2), 1'b0, 11'd0, 1'b0, 1'b0, "");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, "");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v;
        int modes[9];
        modes = '{2, 2, 2, 0, 2, 2, 2, 0, 0};
        rst_n = 1'b0; enable = 1'b0; duty_req = 11'd0; PWM_synch = 1'b0;
        ovr_I_blank = 1'b0; OVR_I = 1'b0; clr_fault = 1'b0;

        cyc(1'b1, 1'b0, 1'b0, 1'b1, 11'd0, 1'b0, 1'b0, "reset_state");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, "");
        rst_n = 1'b1;
        period(0, 1'b1, 11'd0, 1'b0, 1'b0, "idle_no_enable");

        // Soft-start ramp to 100.
        enable = 1'b1; duty_req = 11'd100;
        for (int k = 1; k <= 6; k++) period(0, 1'b1, 11'(16 * k), 1'b1, 1'b0, "ramp_up");
        period(0, 1'b1, 11'd100, 1'b1, 1'b0, "ramp_land_100");
        period(0, 1'b1, 11'd100, 1'b1, 1'b0, "run_hold_100");

        // Slew toward an over-range request, clamped at MAX_DUTY.
        duty_req = 11'h7FF;
        for (int k = 1; k <= 118; k++) begin
            v = 100 + 16 * k;
            if (v > 1983) v = 1983;
            period(0, 1'b1, v[10:0], 1'b1, 1'b0, "slew_up");
        end
        period(0, 1'b1, 11'h7BF, 1'b1, 1'b0, "clamp_max");

        // Blanked over-current never trips; four unblanked periods do.
        repeat (10) period(1, 1'b1, 11'h7BF, 1'b1, 1'b0, "blanked_oc");
        period(2, 1'b1, 11'h7BF, 1'b1, 1'b0, "oc_period1");
        period(2, 1'b1, 11'h7BF, 1'b1, 1'b0, "oc_period2");
        period(2, 1'b1, 11'h7BF, 1'b1, 1'b0, "oc_period3");
        period(2, 1'b1, 11'h7BF, 1'b1, 1'b0, "oc_period4");
        period(0, 1'b1, 11'd0, 1'b0, 1'b1, "trip_fault");

        // clr_fault ignored while enabled, honoured once enable drops.
        clr_fault = 1'b1;
        period(0, 1'b1, 11'd0, 1'b0, 1'b1, "clr_ignored_period");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 11'd0, 1'b0, 1'b1, "clr_ignored_cycle");
        enable = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 11'd0, 1'b0, 1'b0, "clr_exit");
        clr_fault = 1'b0;
        period(0, 1'b1, 11'd0, 1'b0, 1'b0, "idle_after_clr");

        // Non-consecutive over-current periods reset the trip count.
        enable = 1'b1; duty_req = 11'd100;
        for (int k = 1; k <= 6; k++) period(0, 1'b1, 11'(16 * k), 1'b1, 1'b0, "reramp");
        period(0, 1'b1, 11'd100, 1'b1, 1'b0, "reramp_land");
        for (int i = 0; i < 9; i++) period(modes[i], 1'b1, 11'd100, 1'b1, 1'b0, "no_trip_gap");

        // Enable drop ramps down; re-enable ramps back; full drop returns to IDLE.
        enable = 1'b0;
        period(0, 1'b1, 11'd84, 1'b1, 1'b0, "down_84");
        period(0, 1'b1, 11'd68, 1'b1, 1'b0, "down_68");
        period(0, 1'b1, 11'd52, 1'b1, 1'b0, "down_52");
        enable = 1'b1;
        period(0, 1'b1, 11'd68, 1'b1, 1'b0, "back_up_68");
        period(0, 1'b1, 11'd84, 1'b1, 1'b0, "back_up_84");
        period(0, 1'b1, 11'd100, 1'b1, 1'b0, "back_up_100");
        enable = 1'b0;
        for (int k = 1; k <= 6; k++) period(0, 1'b1, 11'(100 - 16 * k), 1'b1, 1'b0, "down_to_zero");
        period(0, 1'b1, 11'd0, 1'b0, 1'b0, "down_idle");
        period(0, 1'b1, 11'd0, 1'b0, 1'b0, "idle_stays");

        // Asynchronous reset mid-ramp at 48.
        enable = 1'b1;
        period(0, 1'b1, 11'd16, 1'b1, 1'b0, "pre_reset_16");
        period(0, 1'b1, 11'd32, 1'b1, 1'b0, "pre_reset_32");
        period(0, 1'b1, 11'd48, 1'b1, 1'b0, "pre_reset_48");
        #1;
        rst_n = 1'b0;
        push_exp(11'd0, 1'b0, 1'b0, "async_reset");
        -> async_ev;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 11'd0, 1'b0, 1'b0, "reset_hold");
        rst_n = 1'b1;
        period(0, 1'b1, 11'd16, 1'b1, 1'b0, "ramp_after_reset");

`ifdef AUTO_RETRY_EN
        period(2, 1'b1, 11'd32, 1'b1, 1'b0, "ar_oc1");
        period(2, 1'b1, 11'd48, 1'b1, 1'b0, "ar_oc2");
        period(2, 1'b1, 11'd64, 1'b1, 1'b0, "ar_oc3");
        period(2, 1'b1, 11'd80, 1'b1, 1'b0, "ar_oc4");
        period(0, 1'b1, 11'd0, 1'b0, 1'b1, "ar_trip");
        for (int i = 1; i <= 1023; i++) period(0, (i == 1023), 11'd0, 1'b0, 1'b1, "ar_still_fault");
        period(0, 1'b1, 11'd0, 1'b0, 1'b0, "ar_retry_idle");
        period(0, 1'b1, 11'd16, 1'b1, 1'b0, "ar_reramp");
`endif

        cyc(1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, "");
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
